// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM pattern test master.
// Holds the run state encoding, the test pattern and the default parameter values.
package sdram_test_pkg;

    // Run sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_REL = 3'd2,
        RD_REQ = 3'd3,
        RD_REL = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] DEF_ADDR_FIRST  = 32'h0000_0000;
    localparam logic [31:0] DEF_ADDR_LAST   = 32'h0000_03FF;
    localparam logic [15:0] DEF_SEED        = 16'hA5C3;
    localparam int          DEF_TIMEOUT_CYC = 4096;

    // Deterministic pattern: only the low 16 address bits take part,
    // so callers pass the low half of the word address.
    function automatic logic [15:0] data(input logic [15:0] a, input logic [15:0] seed);
        return a ^ seed;
    endfunction

endpackage

// File: rtl/sdram_test_master_if.sv
// SRAM-like memory request interface exported by the DDR3 wrapper.
// The master drives address/control/write data; the slave returns read data and ready.
interface sdram_test_master_if;
    logic [31:0] Addr;
    logic        CS;
    logic        L;
    logic        U;
    logic        WE;
    logic [15:0] WR;
    logic        big_r;
    logic [15:0] RD;
    logic [47:0] RD48;
    logic        ready;

    modport master (
        output Addr, CS, L, U, WE, WR, big_r,
        input  RD, RD48, ready
    );

    modport slave (
        input  Addr, CS, L, U, WE, WR, big_r,
        output RD, RD48, ready
    );
endinterface

// File: rtl/sdram_test_checker.sv
// Read-back checker for the SDRAM pattern test.
// Compares 1 or 4 returned words against the pattern, keeps a saturating
// mismatch count and captures the lowest failing word of the first bad read.
module sdram_test_checker
    import sdram_test_pkg::*;
#(
    parameter int          LANES = 1,
    parameter logic [15:0] SEED  = DEF_SEED
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [31:0]           i_addr,
    input  logic [LANES*16-1:0]   i_rd,
    output logic [15:0]           o_err_cnt,
    output logic [31:0]           o_fail_addr,
    output logic [15:0]           o_fail_data
);

    logic [15:0] r_err_cnt;
    logic [31:0] r_fail_addr;
    logic [15:0] r_fail_data;

    logic [2:0]  w_n_bad;
    logic        w_any_bad;
    logic [31:0] w_bad_addr;
    logic [15:0] w_bad_data;
    logic [16:0] w_sum;

    // Per-lane compare; walking from the top lane down leaves the lowest mismatch captured.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_n_bad    = '0;
        w_any_bad  = 1'b0;
        w_bad_addr = '0;
        w_bad_data = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (i_rd[k*16 +: 16] != data(i_addr[15:0] + 16'(k), SEED)) begin
                w_n_bad    = w_n_bad + 3'd1;
                w_any_bad  = 1'b1;
                w_bad_addr = i_addr + 32'(k);
                w_bad_data = i_rd[k*16 +: 16];
            end
        end
        w_sum = {1'b0, r_err_cnt} + {14'd0, w_n_bad};
    end

    // Error counter with saturation, plus first-fail capture while the count is still zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst || i_clear) begin
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (i_valid) begin
            r_err_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            if (w_any_bad && (r_err_cnt == 16'd0)) begin
                r_fail_addr <= w_bad_addr;
                r_fail_data <= w_bad_data;
            end
        end
    end

    assign o_err_cnt   = r_err_cnt;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;

endmodule

// File: rtl/sdram_test_master.sv
// Pattern write / read-back test master for the DDR3 wrapper SRAM-like port.
// Writes data(a) = a ^ SEED over [ADDR_FIRST, ADDR_LAST], reads it back and
// reports pass/fail, mismatch count, first failing address/data and timeout.
// Optional build macro SDRAM_TEST_BIG_READ_EN: read phase uses 64-bit reads
// (m_big_r=1), stepping by 4 words and checking all four returned words.
module sdram_test_master
    import sdram_test_pkg::*;
#(
    parameter logic [31:0] ADDR_FIRST  = DEF_ADDR_FIRST,
    parameter logic [31:0] ADDR_LAST   = DEF_ADDR_LAST,
    parameter logic [15:0] SEED        = DEF_SEED,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    sdram_test_master_if.master         m,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic                        o_timeout,
    output logic [15:0]                 o_err_cnt,
    output logic [31:0]                 o_fail_addr,
    output logic [15:0]                 o_fail_data
);

`ifdef SDRAM_TEST_BIG_READ_EN
    localparam int   LANES = 4;
    localparam logic BIG_R = 1'b1;
    logic [63:0] w_rd_lanes;
    assign w_rd_lanes = {m.RD48, m.RD};
`else
    localparam int   LANES = 1;
    localparam logic BIG_R = 1'b0;
    logic [15:0] w_rd_lanes;
    logic        w_unused_rd48;
    assign w_rd_lanes    = m.RD;
    assign w_unused_rd48 = ^m.RD48;
`endif

    localparam logic [31:0] RD_STEP = 32'(LANES);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wait;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;

    logic        w_start_run;
    logic        w_expired;
    logic        w_wr_last;
    logic        w_rd_last;
    logic        w_abort;
    logic        w_chk_valid;
    logic [15:0] w_err_cnt;

    assign w_start_run = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_expired   = (r_wait == 32'(TIMEOUT_CYC - 1));
    // Equality before increment keeps ADDR_LAST = all-ones from wrapping.
    assign w_wr_last   = (r_addr == ADDR_LAST);
    assign w_rd_last   = ((r_addr + RD_STEP - 32'd1) == ADDR_LAST);
    assign w_chk_valid = (r_state == RD_REQ) && m.ready;

    // State register; reset returns to IDLE, which drops m_CS on the same edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: request until ready, release until ready falls, abort on wait expiry.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) w_next = WR_REQ;
            end
            WR_REQ: begin
                if (m.ready) begin
                    w_next = WR_REL;
                end else if (w_expired) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            WR_REL: begin
                if (!m.ready) begin
                    w_next = w_wr_last ? RD_REQ : WR_REQ;
                end else if (w_expired) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (m.ready) begin
                    w_next = RD_REL;
                end else if (w_expired) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            RD_REL: begin
                if (!m.ready) begin
                    w_next = w_rd_last ? DONE : RD_REQ;
                end else if (w_expired) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Bus outputs decoded from state; request fields stay stable while in a REQ state.
    always_comb begin
        m.CS    = 1'b0;
        m.WE    = 1'b0;
        m.L     = 1'b0;
        m.U     = 1'b0;
        m.WR    = '0;
        m.big_r = 1'b0;
        m.Addr  = r_addr;
        case (r_state)
            WR_REQ: begin
                m.CS = 1'b1;
                m.WE = 1'b1;
                m.L  = 1'b1;
                m.U  = 1'b1;
                m.WR = data(r_addr[15:0], SEED);
            end
            RD_REQ: begin
                m.CS    = 1'b1;
                m.L     = 1'b1;
                m.U     = 1'b1;
                m.big_r = BIG_R;
            end
            default: ;
        endcase
    end

    // Address walk, per-state wait counter and run status flags.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_addr    <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if ((w_next != r_state) || (r_state == IDLE) || (r_state == DONE)) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + 32'd1;
            end

            if (w_start_run) begin
                r_addr    <= ADDR_FIRST;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_pass    <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                if ((r_state == WR_REL) && !m.ready) begin
                    r_addr <= w_wr_last ? ADDR_FIRST : r_addr + 32'd1;
                end
                if ((r_state == RD_REL) && !m.ready && !w_rd_last) begin
                    r_addr <= r_addr + RD_STEP;
                end
                if (w_abort) begin
                    r_timeout <= 1'b1;
                end
                if ((w_next == DONE) && (r_state != DONE)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (w_err_cnt == 16'd0) && !w_abort && !r_timeout;
                end
            end
        end
    end

    sdram_test_checker #(
        .LANES (LANES),
        .SEED  (SEED)
    ) u_checker (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_clear     (w_start_run),
        .i_valid     (w_chk_valid),
        .i_addr      (r_addr),
        .i_rd        (w_rd_lanes),
        .o_err_cnt   (w_err_cnt),
        .o_fail_addr (o_fail_addr),
        .o_fail_data (o_fail_data)
    );

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_pass    = r_pass;
    assign o_timeout = r_timeout;
    assign o_err_cnt = w_err_cnt;

endmodule

// File: tb/tb_sdram_test_master.sv
// Self-checking bench for sdram_test_master: two DUTs (range 0..15 with a
// short timeout, and a range at the top of the address space), each with an
// ideal memory model that can corrupt words or withhold ready.
`timescale 1ns/1ps
module tb_sdram_test_master;

    localparam logic [15:0] SEED   = 16'hA5C3;
    localparam int          TO_CYC = 16;
    localparam int          BOUND  = 3000;
    localparam int          A_WORDS = 16;
`ifdef SDRAM_TEST_BIG_READ_EN
    localparam int          LANES   = 4;
    localparam logic [31:0] B_FIRST = 32'hFFFF_FFFC;
`else
    localparam int          LANES   = 1;
    localparam logic [31:0] B_FIRST = 32'hFFFF_FFFF;
`endif
    localparam logic [31:0] B_LAST  = 32'hFFFF_FFFF;
    localparam int          B_WORDS = int'(B_LAST - B_FIRST) + 1;
    localparam int          A_READS = A_WORDS / LANES;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] wdata;
    } wr_t;

    logic clk;
    logic rst;
    logic start_a;
    logic start_b;

    logic        busy_a, done_a, pass_a, to_a;
    logic [15:0] err_a, fdata_a;
    logic [31:0] faddr_a;
    logic        busy_b, done_b, pass_b, to_b;
    logic [15:0] err_b, fdata_b;
    logic [31:0] faddr_b;

    sdram_test_master_if bus_a ();
    sdram_test_master_if bus_b ();

    sdram_test_master #(
        .ADDR_FIRST  (32'h0000_0000),
        .ADDR_LAST   (32'h0000_000F),
        .SEED        (SEED),
        .TIMEOUT_CYC (TO_CYC)
    ) dut_a (
        .clk (clk), .i_rst (rst), .i_start (start_a), .m (bus_a),
        .o_busy (busy_a), .o_done (done_a), .o_pass (pass_a), .o_timeout (to_a),
        .o_err_cnt (err_a), .o_fail_addr (faddr_a), .o_fail_data (fdata_a)
    );

    sdram_test_master #(
        .ADDR_FIRST  (B_FIRST),
        .ADDR_LAST   (B_LAST),
        .SEED        (SEED),
        .TIMEOUT_CYC (TO_CYC)
    ) dut_b (
        .clk (clk), .i_rst (rst), .i_start (start_b), .m (bus_b),
        .o_busy (busy_b), .o_done (done_b), .o_pass (pass_b), .o_timeout (to_b),
        .o_err_cnt (err_b), .o_fail_addr (faddr_b), .o_fail_data (fdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    wr_t sb_a[$];
    wr_t sb_b[$];
    wr_t exp_a;
    wr_t exp_b;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [4];
    logic [15:0] corrupt_a;
    logic        hang_a;
    logic        rdy_a, rdy_b;
    logic [15:0] rd_a, rd_b;
    logic [47:0] rd48_a, rd48_b;
    int          cnt_a, cnt_b;
    int          wr_cnt_a = 0, rd_cnt_a = 0, wr_cnt_b = 0, rd_cnt_b = 0;

    assign bus_a.ready = rdy_a;
    assign bus_a.RD    = rd_a;
    assign bus_a.RD48  = rd48_a;
    assign bus_b.ready = rdy_b;
    assign bus_b.RD    = rd_b;
    assign bus_b.RD48  = rd48_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_word_a(input logic [3:0] i);
        return mem_a[i] ^ {15'd0, corrupt_a[i]};
    endfunction

    // Memory model A: ready 3 cycles after CS, drops the cycle after CS falls.
    always @(negedge clk) begin
        if (rst) begin
            rdy_a <= 1'b0;
            cnt_a <= 0;
        end else if (!bus_a.CS) begin
            rdy_a <= 1'b0;
            cnt_a <= 0;
        end else if (!rdy_a && !hang_a) begin
            if (cnt_a < 2) begin
                cnt_a <= cnt_a + 1;
            end else begin
                rdy_a <= 1'b1;
                check("a_L", bus_a.L, 1);
                check("a_U", bus_a.U, 1);
                if (bus_a.WE) begin
                    check("a_big_r_wr", bus_a.big_r, 0);
                    check("a_write_expected", 64'(sb_a.size() != 0), 1);
                    if (sb_a.size() != 0) begin
                        exp_a = sb_a.pop_front();
                        check("a_wr_addr", bus_a.Addr, exp_a.addr);
                        check("a_wr_data", bus_a.WR, exp_a.wdata);
                    end
                    mem_a[bus_a.Addr[3:0]] <= bus_a.WR;
                    wr_cnt_a <= wr_cnt_a + 1;
                end else begin
                    check("a_big_r_rd", bus_a.big_r, (LANES == 4) ? 1 : 0);
                    rd_a   <= rd_word_a(bus_a.Addr[3:0]);
                    rd48_a <= {rd_word_a(bus_a.Addr[3:0] + 4'd3),
                               rd_word_a(bus_a.Addr[3:0] + 4'd2),
                               rd_word_a(bus_a.Addr[3:0] + 4'd1)};
                    rd_cnt_a <= rd_cnt_a + 1;
                end
            end
        end
    end

    // Memory model B: same timing, four words at the top of the address space.
    always @(negedge clk) begin
        if (rst) begin
            rdy_b <= 1'b0;
            cnt_b <= 0;
        end else if (!bus_b.CS) begin
            rdy_b <= 1'b0;
            cnt_b <= 0;
        end else if (!rdy_b) begin
            if (cnt_b < 2) begin
                cnt_b <= cnt_b + 1;
            end else begin
                rdy_b <= 1'b1;
                if (bus_b.WE) begin
                    check("b_write_expected", 64'(sb_b.size() != 0), 1);
                    if (sb_b.size() != 0) begin
                        exp_b = sb_b.pop_front();
                        check("b_wr_addr", bus_b.Addr, exp_b.addr);
                        check("b_wr_data", bus_b.WR, exp_b.wdata);
                    end
                    mem_b[bus_b.Addr[1:0]] <= bus_b.WR;
                    wr_cnt_b <= wr_cnt_b + 1;
                end else begin
                    rd_b   <= mem_b[bus_b.Addr[1:0]];
                    rd48_b <= {mem_b[bus_b.Addr[1:0] + 2'd3],
                               mem_b[bus_b.Addr[1:0] + 2'd2],
                               mem_b[bus_b.Addr[1:0] + 2'd1]};
                    rd_cnt_b <= rd_cnt_b + 1;
                end
            end
        end
    end

    task automatic push_writes_a();
        for (int a = 0; a < A_WORDS; a++) begin
            sb_a.push_back('{addr: 32'(a), wdata: 16'(a) ^ SEED});
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Waits for o_done with a cycle budget, counting cycles with o_busy high.
    task automatic wait_done_a(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < BOUND && !done_a; i++) begin
            if (busy_a) busy_cycles++;
            @(negedge clk);
        end
        check("a_done_within_bound", done_a, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy_a,   0);
        check({tag, "_done"},  done_a,   0);
        check({tag, "_pass"},  pass_a,   0);
        check({tag, "_to"},    to_a,     0);
        check({tag, "_err"},   err_a,    0);
        check({tag, "_faddr"}, faddr_a,  0);
        check({tag, "_fdata"}, fdata_a,  0);
        check({tag, "_cs"},    bus_a.CS, 0);
        check({tag, "_we"},    bus_a.WE, 0);
        check({tag, "_addr"},  bus_a.Addr, 0);
    endtask

    int busy_cyc;
    int rd_base;
    int wr_base;
    int found;

    initial begin
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        hang_a    = 1'b0;
        corrupt_a = 16'h0000;
        rd_a = '0; rd48_a = '0; rd_b = '0; rd48_b = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_b_cs", bus_b.CS, 0);
        rst = 1'b0;

        // Clean run over 0..15
        push_writes_a();
        rd_base = rd_cnt_a;
        pulse_start_a();
        check("clean_busy", busy_a, 1);
        wait_done_a(busy_cyc);
        check("clean_pass", pass_a, 1);
        check("clean_err", err_a, 0);
        check("clean_to", to_a, 0);
        check("clean_busy_end", busy_a, 0);
        check("clean_cs_end", bus_a.CS, 0);
        check("clean_writes_left", sb_a.size(), 0);
        check("clean_reads", rd_cnt_a - rd_base, A_READS);

        // Single corrupted word at address 5
        corrupt_a = 16'h0020;
        push_writes_a();
        pulse_start_a();
        wait_done_a(busy_cyc);
        check("c5_err", err_a, 1);
        check("c5_faddr", faddr_a, 5);
        check("c5_fdata", fdata_a, 16'h0005 ^ SEED ^ 16'h0001);
        check("c5_pass", pass_a, 0);
        check("c5_to", to_a, 0);
        corrupt_a = 16'h0000;

        // Memory never answers: abort after TO_CYC wait cycles
        hang_a  = 1'b1;
        wr_base = wr_cnt_a;
        pulse_start_a();
        check("to_pass_cleared", pass_a, 0);
        wait_done_a(busy_cyc);
        check("to_flag", to_a, 1);
        check("to_cs", bus_a.CS, 0);
        check("to_pass", pass_a, 0);
        check("to_busy_cycles", busy_cyc, TO_CYC);
        check("to_no_writes", wr_cnt_a - wr_base, 0);
        hang_a = 1'b0;

        // Reset during a read request, then a clean run
        push_writes_a();
        pulse_start_a();
        found = 0;
        for (int i = 0; i < BOUND && found == 0; i++) begin
            if (bus_a.CS && !bus_a.WE) found = 1;
            else @(negedge clk);
        end
        check("rst_reached_read", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_writes_left", sb_a.size(), 0);
        push_writes_a();
        pulse_start_a();
        wait_done_a(busy_cyc);
        check("after_rst_pass", pass_a, 1);
        check("after_rst_err", err_a, 0);

`ifdef SDRAM_TEST_BIG_READ_EN
        // Big reads with words 2 and 3 corrupted in the same 64-bit read
        corrupt_a = 16'h000C;
        push_writes_a();
        rd_base = rd_cnt_a;
        pulse_start_a();
        wait_done_a(busy_cyc);
        check("big_err", err_a, 2);
        check("big_faddr", faddr_a, 2);
        check("big_fdata", fdata_a, 16'h0002 ^ SEED ^ 16'h0001);
        check("big_pass", pass_a, 0);
        check("big_reads", rd_cnt_a - rd_base, A_READS);
        corrupt_a = 16'h0000;
`endif

        // Top-of-space range: no wrap past 32'hFFFF_FFFF
        for (int i = 0; i < B_WORDS; i++) begin
            sb_b.push_back('{addr: B_FIRST + 32'(i), wdata: 16'(B_FIRST + 32'(i)) ^ SEED});
        end
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < BOUND && !done_b; i++) @(negedge clk);
        check("b_done_within_bound", done_b, 1);
        check("b_pass", pass_b, 1);
        check("b_writes", wr_cnt_b, B_WORDS);
        check("b_reads", rd_cnt_b, 1);
        check("b_writes_left", sb_b.size(), 0);
        check("b_addr_end", bus_b.Addr, B_LAST);
        repeat (10) @(negedge clk);
        check("b_no_extra_writes", wr_cnt_b, B_WORDS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
